regfile_wr_scoreboard: RTL

//   Parametrised successor to the combinational register-number decoder. Decodes the writeback

---
 rtl/regfile_wr_scoreboard_if.sv | 31 +++
 rtl/regfile_wr_scoreboard.sv | 91 +++++++++
 2 files changed

// File: rtl/regfile_wr_scoreboard_if.sv
// Issue/writeback bundle between the issue stage, the register-file
// write-enable decoder and anything that observes the busy scoreboard.
interface regfile_wr_scoreboard_if #(
  parameter int ADDR_W = 5
);
  localparam int NREGS = 2 ** ADDR_W;

  logic              iss_valid;
  logic [ADDR_W-1:0] iss_rd;
  logic              iss_ready;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_rd;
  logic              flush;
  logic              err_clr;
  logic [NREGS-1:0]  we_onehot;
  logic [NREGS-1:0]  busy;
  logic [ADDR_W:0]   busy_cnt;
  logic              err_stray;

  // Issue/writeback side: drives requests, observes the scoreboard.
  modport master (
    output iss_valid, iss_rd, wb_valid, wb_rd, flush, err_clr,
    input  iss_ready, we_onehot, busy, busy_cnt, err_stray
  );

  // Scoreboard side.
  modport slave (
    input  iss_valid, iss_rd, wb_valid, wb_rd, flush, err_clr,
    output iss_ready, we_onehot, busy, busy_cnt, err_stray
  );
endinterface

// File: rtl/regfile_wr_scoreboard.sv
// Writeback register-number decoder with a per-register busy scoreboard.
// Produces a registered one-hot write enable one cycle after wb_valid and
// stalls issue when the destination already has a write outstanding (WAW).
module regfile_wr_scoreboard #(
  parameter int ADDR_W      = 5,
  parameter bit ZERO_REG_RO = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  regfile_wr_scoreboard_if.slave  sb
);
  localparam int              NREGS    = 2 ** ADDR_W;
  localparam logic [NREGS-1:0] ONE_HOT0 = {{(NREGS-1){1'b0}}, 1'b1};

  logic [NREGS-1:0] we_onehot_q, we_onehot_d;
  logic [NREGS-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  busy_cnt_q, busy_cnt_d;
  logic             err_stray_q, err_stray_d;

  logic iss_hw_zero;
  logic wb_hw_zero;
  logic wb_bypass;
  logic iss_ready;
  logic iss_fire;
  logic stray_set;

  // Hardwired-zero detection for both ports.
  assign iss_hw_zero = ZERO_REG_RO && (sb.iss_rd == '0);
  assign wb_hw_zero  = ZERO_REG_RO && (sb.wb_rd == '0);

  // A write retiring this cycle frees its register for a same-cycle issue.
  assign wb_bypass = sb.wb_valid && (sb.wb_rd == sb.iss_rd);
  assign iss_ready = !busy_q[sb.iss_rd] || wb_bypass || iss_hw_zero;

  // Flush drops the issue even when the handshake completes.
  assign iss_fire  = sb.iss_valid && iss_ready && !sb.flush;

  // Writeback to a register with nothing outstanding is a protocol error.
  assign stray_set = sb.wb_valid && !sb.flush && !busy_q[sb.wb_rd] && !wb_hw_zero;

  // Per-register busy next state: flush, then issue set, then writeback clear.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy
    localparam bit HARDWIRED = ZERO_REG_RO && (gi == 0);
    logic set_i;
    logic clr_i;
    assign set_i = iss_fire && (sb.iss_rd == ADDR_W'(gi)) && !HARDWIRED;
    assign clr_i = sb.wb_valid && (sb.wb_rd == ADDR_W'(gi));
    assign busy_d[gi] = sb.flush ? 1'b0 :
                        set_i    ? 1'b1 :
                        clr_i    ? 1'b0 : busy_q[gi];
  end

  // Decode, popcount of the next busy vector and sticky error next state.
  always_comb begin
    we_onehot_d = '0;
    busy_cnt_d  = '0;
    err_stray_d = err_stray_q;
    if (sb.wb_valid && !wb_hw_zero) begin
      we_onehot_d = ONE_HOT0 << sb.wb_rd;
    end
    for (int i = 0; i < NREGS; i++) begin
      busy_cnt_d = busy_cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
    end
    if (stray_set) begin
      err_stray_d = 1'b1;
    end else if (sb.err_clr) begin
      err_stray_d = 1'b0;
    end
  end

  // State registers; reset discards all outstanding writes at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      we_onehot_q <= '0;
      busy_q      <= '0;
      busy_cnt_q  <= '0;
      err_stray_q <= 1'b0;
    end else begin
      we_onehot_q <= we_onehot_d;
      busy_q      <= busy_d;
      busy_cnt_q  <= busy_cnt_d;
      err_stray_q <= err_stray_d;
    end
  end

  assign sb.iss_ready = iss_ready;
  assign sb.we_onehot = we_onehot_q;
  assign sb.busy      = busy_q;
  assign sb.busy_cnt  = busy_cnt_q;
  assign sb.err_stray = err_stray_q;
endmodule
